zigzag_block_loader: RTL and testbench
======================================

Name: zigzag_block_loader

Overview:
- Upstream neighbour of the CAVLC pre-processing stage.
- Accepts one 4x4 block of quantised coefficients as a serial raster-order stream, one coefficient per cycle, under a valid/ready handshake.
- Reorders the block into zig-zag scan order and presents all 16 coefficients in parallel, together with a running non-zero count, under an output valid/ready handshake.
- The 16 output slices drive the pre-processor's 16 coefficient inputs directly.

Parameters:
- WIDTH, 8, bit width of one coefficient (two's complement).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_coeff is valid this cycle.
- in_ready  output  1  block can accept a coefficient this cycle.
- in_coeff  input  WIDTH  next coefficient in raster order (row-major, r = 4*row + col).
- abort  input  1  synchronous flush of the partially filled block.
- out_valid  output  1  zz_bus holds a complete block.
- out_ready  input  1  downstream consumes the block this cycle.
- zz_bus  output  16*WIDTH  slice k, bits [k*WIDTH +: WIDTH], is zig-zag position k.
- nz_count  output  5  number of non-zero coefficients in the presented block, 0..16.

Behaviour:
- Accept: a coefficient is accepted when in_valid && in_ready at a rising edge.
- Raster index: an internal 4-bit counter cnt gives the raster index of each accepted coefficient. cnt increments on every accept and wraps 15 -> 0 at the end of the block.
- Zig-zag map (raster r -> zig-zag position k): 0->0, 1->1, 2->5, 3->6, 4->2, 5->4, 6->7, 7->12, 8->3, 9->8, 10->11, 11->13, 12->9, 13->10, 14->14, 15->15.
- Fill buffer: each accepted coefficient is written into fill-buffer slot map(cnt).
- Non-zero accumulator: a 5-bit accumulator adds 1 for each accepted coefficient != 0. It is cleared at block start.
- State machine (single-buffer build), two states:
  - FILL: in_ready = 1, out_valid = 0. The accept with cnt == 15 moves to FULL.
  - FULL: in_ready = 0, out_valid = 1. zz_bus and nz_count are stable. out_ready moves to FILL, with cnt = 0 and the accumulator cleared.
- Latency: out_valid rises on the cycle after the 16th accept, and drops on the cycle after the out_ready handshake.
- zz_bus after hand-off: retains its last contents after hand-off until overwritten; it is never cleared except by reset.
- Throughput: single-buffer build gives 16 input cycles plus at least 1 output-handshake cycle per block.
- abort (synchronous):
  - Forces cnt = 0, clears the accumulator, state = FILL.
  - Has priority over a same-cycle accept, which is dropped.
  - In FULL, abort also discards the presented block, so out_valid = 0 the next cycle.
- out_ready while out_valid = 0: ignored.
- in_valid while in_ready = 0: ignored; the data is not captured.
- Reset values (asynchronous): state FILL, cnt 0, accumulator 0, zz_bus all 0, nz_count 0, out_valid 0. in_ready is 1 once reset is released.
- Width rules:
  - Zero test uses all WIDTH bits.
  - nz_count is 5 bits, so 16 is representable.

Optional Feature:
- Macro: ZZ_DOUBLE_BUFFER_EN.
- Defined:
  - Two banks (fill bank and output bank), each with its own nz_count.
  - in_ready = 0 only when both banks are full.
  - On the 16th accept, the fill bank swaps to output if the output bank is empty or is handed off the same cycle. Otherwise the fill bank holds as full.
  - 16th accept coinciding with an output handshake: out_valid stays 1 and the new block is presented on the next cycle, giving zero bubble.
  - Back-to-back blocks stream at 16 cycles per block.
  - abort clears only the fill bank; the output bank is unaffected.
- Undefined: single-buffer behaviour as above.

Test Plan:
- Raster 1..16, in_valid held high, out_ready high:
  - zz_bus slices k = 0..15 read 1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16.
  - nz_count = 16.
  - out_valid is high exactly 1 cycle, on the cycle after the 16th accept.
- Block of raster values 0, 3, 0, 0, -1 (8'hFF), then 11 zeros:
  - zz slice 1 = 3, slice 2 = 8'hFF, all other slices 0.
  - nz_count = 2.
- Full block with out_ready held low for 5 cycles:
  - out_valid stays 1, in_ready stays 0, bus is stable.
  - A second block's first coefficient, offered during the stall, is not captured.
  - After out_ready, in_ready returns to 1 the next cycle.
- abort asserted after 7 accepts (same cycle as an 8th in_valid):
  - The 8th is dropped.
  - The next 16 accepts form a complete block; nz_count counts only those 16.
- rst asserted mid-fill, then mid-FULL:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - in_ready = 1 once reset is released.
- ZZ_DOUBLE_BUFFER_EN build, two blocks back-to-back with out_ready high:
  - Second out_valid pulse follows 16 cycles after the first.
  - in_ready never drops.
  - Both bus images are correct.

Source files
------------

// File: rtl/zigzag_block_loader.sv
// Serial raster-order 4x4 coefficient loader that presents the block in zig-zag order with a non-zero count.
// Define ZZ_DOUBLE_BUFFER_EN for the two-bank build (fill bank + output bank, zero-bubble streaming).
module zigzag_block_loader #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_coeff,
   input  logic                  abort,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WIDTH-1:0]   zz_bus,
   output logic [4:0]            nz_count
);

   function automatic logic [3:0] zz_pos(input logic [3:0] r);
      case (r)
         4'd0:  zz_pos = 4'd0;   4'd1:  zz_pos = 4'd1;
         4'd2:  zz_pos = 4'd5;   4'd3:  zz_pos = 4'd6;
         4'd4:  zz_pos = 4'd2;   4'd5:  zz_pos = 4'd4;
         4'd6:  zz_pos = 4'd7;   4'd7:  zz_pos = 4'd12;
         4'd8:  zz_pos = 4'd3;   4'd9:  zz_pos = 4'd8;
         4'd10: zz_pos = 4'd11;  4'd11: zz_pos = 4'd13;
         4'd12: zz_pos = 4'd9;   4'd13: zz_pos = 4'd10;
         4'd14: zz_pos = 4'd14;  default: zz_pos = 4'd15;
      endcase
   endfunction

   logic [3:0] cnt_q, cnt_d;
   logic [4:0] acc_q, acc_d;
   logic [3:0] pos;
   logic [4:0] nz_inc;

   assign pos    = zz_pos(cnt_q);
   assign nz_inc = {4'd0, |in_coeff};

`ifdef ZZ_DOUBLE_BUFFER_EN
   logic [15:0][WIDTH-1:0] fb_q, fb_d, ob_q, ob_d;
   logic                   fb_full_q, fb_full_d, ob_valid_q, ob_valid_d;
   logic [4:0]             ob_nz_q, ob_nz_d;
   logic                   handoff, ob_free;

   assign handoff   = ob_valid_q && out_ready;
   assign ob_free   = !ob_valid_q || handoff;
   assign in_ready  = !fb_full_q && !rst;
   assign out_valid = ob_valid_q;
   assign zz_bus    = ob_q;
   assign nz_count  = ob_nz_q;

   always_comb begin
      fb_d       = fb_q;
      ob_d       = ob_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      fb_full_d  = fb_full_q;
      ob_valid_d = ob_valid_q && !handoff;
      ob_nz_d    = ob_nz_q;
      if (abort) begin
         cnt_d     = 4'd0;
         acc_d     = 5'd0;
         fb_full_d = 1'b0;
      end else if (fb_full_q) begin
         if (ob_free) begin
            ob_d       = fb_q;
            ob_nz_d    = acc_q;
            ob_valid_d = 1'b1;
            fb_full_d  = 1'b0;
            acc_d      = 5'd0;
         end
      end else if (in_valid) begin
         fb_d[pos] = in_coeff;
         acc_d     = acc_q + nz_inc;
         cnt_d     = cnt_q + 4'd1;
         // Last coefficient goes straight to the output bank when it is free.
         if (cnt_q == 4'd15) begin
            if (ob_free) begin
               ob_d       = fb_d;
               ob_nz_d    = acc_d;
               ob_valid_d = 1'b1;
               acc_d      = 5'd0;
            end else begin
               fb_full_d  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fb_q       <= '0;
         ob_q       <= '0;
         cnt_q      <= 4'd0;
         acc_q      <= 5'd0;
         fb_full_q  <= 1'b0;
         ob_valid_q <= 1'b0;
         ob_nz_q    <= 5'd0;
      end else begin
         fb_q       <= fb_d;
         ob_q       <= ob_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         fb_full_q  <= fb_full_d;
         ob_valid_q <= ob_valid_d;
         ob_nz_q    <= ob_nz_d;
      end
   end
`else
   typedef enum logic {FILL, FULL} state_t;
   state_t                 state_q, state_d;
   logic [15:0][WIDTH-1:0] zz_q, zz_d;

   assign in_ready  = (state_q == FILL) && !rst;
   assign out_valid = (state_q == FULL);
   assign zz_bus    = zz_q;
   assign nz_count  = acc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      zz_d    = zz_q;
      if (abort) begin
         state_d = FILL;
         cnt_d   = 4'd0;
         acc_d   = 5'd0;
      end else begin
         case (state_q)
            FILL: if (in_valid) begin
               zz_d[pos] = in_coeff;
               acc_d     = acc_q + nz_inc;
               cnt_d     = cnt_q + 4'd1;
               if (cnt_q == 4'd15) state_d = FULL;
            end
            default: if (out_ready) begin
               state_d = FILL;
               cnt_d   = 4'd0;
               acc_d   = 5'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= 4'd0;
         acc_q   <= 5'd0;
         zz_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         zz_q    <= zz_d;
      end
   end
`endif

endmodule

// File: tb/tb_zigzag_block_loader.sv
// Directed bench for zigzag_block_loader; define ZZ_DOUBLE_BUFFER_EN to exercise the two-bank build.
module tb_zigzag_block_loader;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [7:0]   in_coeff = 8'd0;
   logic         abort = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] zz_bus;
   logic [4:0]   nz_count;

   int checks = 0;
   int errors = 0;

   localparam int ZZ [16] = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};

   zigzag_block_loader #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_coeff(in_coeff), .abort(abort), .out_valid(out_valid),
      .out_ready(out_ready), .zz_bus(zz_bus), .nz_count(nz_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] zz_of(input logic [7:0] v[16]);
      logic [127:0] b = '0;
      for (int r = 0; r < 16; r++) b[ZZ[r]*8 +: 8] = v[r];
      return b;
   endfunction

   // Feeds 16 coefficients back-to-back; out_valid must stay low until the last accept.
   task automatic send_block(input logic [7:0] v[16]);
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1;
         in_coeff = v[i];
         step();
         if (i < 15) chk("ov_low_during_fill", out_valid, 1'b0);
      end
      in_valid = 1'b0;
   endtask

   logic [7:0]   va[16], vb[16], vz[16];
   logic [127:0] exp1, capt;
   int           pulses;

   initial begin
      for (int i = 0; i < 16; i++) begin
         va[i] = 8'(i + 1);
         vb[i] = (i % 3 == 0) ? 8'd0 : 8'(8'h80 + i);
         vz[i] = 8'd0;
      end
      vz[1] = 8'd3;
      vz[4] = 8'hFF;
      begin
         logic [7:0] k_img [16] = '{1, 2, 5, 9, 6, 3, 4, 7, 10, 13, 14, 11, 8, 12, 15, 16};
         exp1 = '0;
         for (int k = 0; k < 16; k++) exp1[k*8 +: 8] = k_img[k];
      end

      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_nz", nz_count, 5'd0);
      chk("rst_bus", zz_bus, 128'd0);
      #10 rst = 1'b0;
      #1;
      chk("rst_rel_in_ready", in_ready, 1'b1);

      // Raster 1..16 with out_ready high: single-cycle out_valid pulse.
      out_ready = 1'b1;
      send_block(va);
      chk("t1_out_valid", out_valid, 1'b1);
      chk("t1_bus", zz_bus, exp1);
      chk("t1_nz", nz_count, 5'd16);
      step();
      chk("t1_pulse_end", out_valid, 1'b0);
      chk("t1_bus_retained", zz_bus, exp1);

      // Sparse block incl. a negative coefficient.
      send_block(vz);
      chk("t2_bus", zz_bus, {112'd0, 8'hFF, 8'd3, 8'd0});
      chk("t2_nz", nz_count, 5'd2);
      step();

`ifndef ZZ_DOUBLE_BUFFER_EN
      // Stall: out_ready low for 5 cycles, a new coefficient offered meanwhile.
      out_ready = 1'b0;
      send_block(vb);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_coeff = 8'h55;
         step();
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_bus", zz_bus, zz_of(vb));
         chk("stall_nz", nz_count, 5'd10);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("stall_release_ov", out_valid, 1'b0);
      chk("stall_release_ir", in_ready, 1'b1);
      send_block(va);
      chk("after_stall_bus", zz_bus, exp1);
      step();
`endif

      // Abort after 7 accepts, coinciding with an 8th in_valid.
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1;
         in_coeff = 8'h77;
         step();
      end
      in_coeff = 8'h99;
      abort = 1'b1;
      step();
      abort = 1'b0;
      send_block(vb);
      chk("abort_bus", zz_bus, zz_of(vb));
      chk("abort_nz", nz_count, 5'd10);
      step();

      // Async reset mid-fill.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_coeff = 8'h11;
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid_fill_ov", out_valid, 1'b0);
      chk("rst_mid_fill_nz", nz_count, 5'd0);
      chk("rst_mid_fill_bus", zz_bus, 128'd0);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid_fill_ir", in_ready, 1'b1);

      // Async reset mid-FULL.
      out_ready = 1'b0;
      send_block(va);
      chk("pre_rst_full_ov", out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rst_full_ov", out_valid, 1'b0);
      chk("rst_full_nz", nz_count, 5'd0);
      chk("rst_full_bus", zz_bus, 128'd0);
      #1 rst = 1'b0;
      #1;
      chk("rst_full_ir", in_ready, 1'b1);
      out_ready = 1'b1;
      step();

`ifdef ZZ_DOUBLE_BUFFER_EN
      // Two blocks streamed back-to-back, out_ready high.
      pulses = 0;
      for (int i = 0; i < 32; i++) begin
         in_valid = 1'b1;
         in_coeff = (i < 16) ? va[i] : vb[i-16];
         step();
         chk("db_in_ready", in_ready, 1'b1);
         if (out_valid) begin
            pulses++;
            if (pulses == 1) begin
               chk("db_first_at", i, 15);
               chk("db_bus_a", zz_bus, exp1);
               chk("db_nz_a", nz_count, 5'd16);
            end else begin
               chk("db_second_at", i, 31);
               capt = zz_bus;
               chk("db_bus_b", capt, zz_of(vb));
               chk("db_nz_b", nz_count, 5'd10);
            end
         end
      end
      in_valid = 1'b0;
      step();
      chk("db_pulse_count", pulses, 2);
      chk("db_idle_ov", out_valid, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
